// File: rtl/pe_pkg.sv
// Shared definitions for the MAC sequencer and its processing element:
// default widths, command length width and the sequencer state encoding.
package pe_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ACC_W_DEF  = 32;
  localparam int unsigned LEN_W      = 8;
  localparam int unsigned BUB_W      = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_OUT    = 3'd4
  } seq_state_e;

endpackage

// File: rtl/mac_sequencer.sv
// MAC sequencer: accepts a command (operand-pair count K and preload psum),
// preloads the external PE accumulator, streams K operand pairs into it,
// waits out the PE latency and returns the accumulated result.
// Optional feature macro: MAC_SEQ_BUBBLE_CNT_EN adds a 16-bit bubble_cnt
// output counting STREAM cycles without an accepted beat.
module mac_sequencer
  import pe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned PE_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [ACC_W-1:0]  cmd_psum,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              pe_en,
  output logic              pe_load_acc,
  output logic [DATA_W-1:0] pe_a,
  output logic [DATA_W-1:0] pe_b,
  output logic [ACC_W-1:0]  pe_psum,
  input  logic [ACC_W-1:0]  pe_acc,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data
`ifdef MAC_SEQ_BUBBLE_CNT_EN
  ,
  output logic [BUB_W-1:0]  bubble_cnt
`endif
);

  localparam int unsigned DRN_W = $clog2(PE_LAT + 1);

  seq_state_e       state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] beat_cnt;
  logic [DRN_W-1:0] drn_cnt;
  logic             last_beat;

  // The beat being accepted this cycle is the K-th of the command
  assign last_beat = (beat_cnt == (len_q - LEN_W'(1)));

  // Sequencer FSM; every output is a register updated alongside the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      len_q       <= '0;
      beat_cnt    <= '0;
      drn_cnt     <= '0;
      cmd_ready   <= 1'b1;
      in_ready    <= 1'b0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      pe_en       <= 1'b0;
      pe_load_acc <= 1'b0;
      pe_a        <= '0;
      pe_b        <= '0;
      pe_psum     <= '0;
`ifdef MAC_SEQ_BUBBLE_CNT_EN
      bubble_cnt  <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            len_q       <= cmd_len;
            pe_psum     <= cmd_psum;
            pe_load_acc <= 1'b1;
            cmd_ready   <= 1'b0;
            state       <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          pe_load_acc <= 1'b0;
          pe_en       <= 1'b1;
          pe_a        <= '0;
          pe_b        <= '0;
          beat_cnt    <= '0;
          drn_cnt     <= '0;
`ifdef MAC_SEQ_BUBBLE_CNT_EN
          bubble_cnt  <= '0;
`endif
          if (len_q != '0) begin
            in_ready <= 1'b1;
            state    <= ST_STREAM;
          end else begin
            state    <= ST_DRAIN;
          end
        end

        ST_STREAM: begin
          if (in_valid) begin
            pe_a     <= in_a;
            pe_b     <= in_b;
            beat_cnt <= beat_cnt + LEN_W'(1);
            if (last_beat) begin
              in_ready <= 1'b0;
              drn_cnt  <= '0;
              state    <= ST_DRAIN;
            end
          end else begin
            pe_a <= '0;
            pe_b <= '0;
`ifdef MAC_SEQ_BUBBLE_CNT_EN
            if (bubble_cnt != {BUB_W{1'b1}}) begin
              bubble_cnt <= bubble_cnt + BUB_W'(1);
            end
`endif
          end
        end

        ST_DRAIN: begin
          pe_a <= '0;
          pe_b <= '0;
          if (drn_cnt == DRN_W'(PE_LAT)) begin
            res_data  <= pe_acc;
            res_valid <= 1'b1;
            pe_en     <= 1'b0;
            state     <= ST_OUT;
          end else begin
            drn_cnt <= drn_cnt + DRN_W'(1);
          end
        end

        ST_OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, operand width.
REQ-002 SHALL have parameter ACC_W, default 32, accumulator/result width.
REQ-003 SHALL have parameter PE_LAT, default 2, cycles from last operand presented to valid pe_acc.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports cmd_valid/cmd_ready  input/output  1  command handshake.
REQ-007 SHALL have ports cmd_len  input  8  (operand-pair count K) and cmd_psum  input  ACC_W  (preload value).
REQ-008 SHALL have ports in_valid/in_ready  input/output  1  and in_a, in_b  input  DATA_W  (operand stream).
REQ-009 SHALL have ports pe_en, pe_load_acc  output  1; pe_a, pe_b  output  DATA_W; pe_psum  output  ACC_W; pe_acc  input  ACC_W (PE drive/return).
REQ-010 SHALL have ports res_valid  output  1, res_ready  input  1, res_data  output  ACC_W.

Function
REQ-011 SHALL implement states IDLE, LOAD, STREAM, DRAIN, OUT.
REQ-012 IDLE: cmd_ready=1; on cmd_valid, latch cmd_len/cmd_psum and go to LOAD.
REQ-013 LOAD: exactly one cycle, pe_load_acc=1, pe_psum=latched psum, pe_en=0; next STREAM if K>0, else DRAIN.
REQ-014 STREAM: in_ready=1, pe_en=1; an accepted beat registers in_a/in_b onto pe_a/pe_b for the following cycle; a non-accepted cycle (bubble) drives pe_a=pe_b=0.
REQ-015 STREAM SHALL count accepted beats; after the K-th beat in_ready deasserts the next cycle and the state goes to DRAIN.
REQ-016 DRAIN: pe_en=1, pe_a=pe_b=0 for exactly PE_LAT cycles, then capture pe_acc into res_data and go to OUT.
REQ-017 OUT: res_valid=1, res_data held stable until res_valid&res_ready, then IDLE; cmd_ready=0 until IDLE.
REQ-018 cmd_ready, in_ready and res_valid SHALL be registered outputs; no combinational path from any ready input to any valid output.
REQ-019 Result arithmetic is the PE's modulo-2^ACC_W sum; the sequencer SHALL NOT saturate or alter pe_acc.
REQ-020 K=0 SHALL yield res_data=cmd_psum via LOAD->DRAIN->OUT.
REQ-021 in_valid outside STREAM SHALL be ignored (in_ready=0); cmd_valid outside IDLE SHALL be ignored.

Reset
REQ-022 On rst_n low, state=IDLE, cmd_ready=1, in_ready=0, res_valid=0, res_data=0, pe_en=0, pe_load_acc=0, pe_a=pe_b=0, pe_psum=0, counters=0.
REQ-023 Reset mid-operation SHALL discard the command with no result emitted; the first command after reset is processed normally.

Configuration
REQ-024 Macro MAC_SEQ_BUBBLE_CNT_EN, when defined, SHALL add output bubble_cnt (16 bits) counting STREAM bubble cycles of the current command, cleared in LOAD, saturating at 16'hFFFF, valid with res_valid.
REQ-025 Without MAC_SEQ_BUBBLE_CNT_EN, the port and counter SHALL be absent; all other behaviour is identical.

Structure
REQ-026 DATA_W/ACC_W defaults and the state enum typedef SHALL live in shared package pe_pkg, also used by pe.
REQ-027 Single module; no sub-module is warranted.

Verification
REQ-028 cmd K=4, psum=0; a=[1,2,3,4], b=[5,6,7,8] back-to-back -> res_data=70.
REQ-029 cmd K=1, psum=1000; a=5, b=5 -> res_data=1025.
REQ-030 K=4 dot product with 3 in_valid gaps -> res_data=70; bubble_cnt=3 when MAC_SEQ_BUBBLE_CNT_EN defined.
REQ-031 cmd K=0, psum=42 -> res_data=42, no in_ready pulse.
REQ-032 res_ready low 5 cycles in OUT -> res_valid and res_data stable, cmd_ready=0; then accept.
REQ-033 rst_n low mid-STREAM -> all outputs at REQ-022 values; next K=1 (65535x65535, psum 0) -> res_data=4294836225.
